// File: rtl/uart_cmd_frame_decoder.sv
// Frames 14-byte host->FPGA UART command packets, checks header/CRC-8/footer and
// presents the decoded fields with a one-cycle strobe; bad frames raise pkt_err.
module uart_cmd_frame_decoder #(
  parameter logic [7:0]  HEADER      = 8'h55,
  parameter logic [7:0]  FOOTER      = 8'hAA,
  parameter logic [7:0]  CRC_POLY    = 8'h07,
  parameter int unsigned TIMEOUT_CYC = 50_000
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        pkt_valid,
  output logic        pkt_err,
  output logic [1:0]  err_code,
  output logic [7:0]  reg_func,
  output logic [7:0]  pwm_ch,
  output logic [7:0]  ctrl_sta,
  output logic [7:0]  duty_num,
  output logic [15:0] pulse_dessert,
  output logic [7:0]  pulse_num,
  output logic [31:0] pattern,
  output logic        busy
);

  localparam int unsigned PAYLOAD_LEN = 11;
  localparam int unsigned CNT_W       = 4;
  localparam int unsigned TMO_W       = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [1:0] {S_IDLE, S_PAYLOAD, S_CRC, S_FOOTER} state_t;

  state_t           state, state_d;
  logic [CNT_W-1:0] byte_cnt, byte_cnt_d;
  logic [7:0]       crc, crc_d;
  logic             crc_ok, crc_ok_d;
  logic [TMO_W-1:0] tmo_cnt;
  logic [7:0]       shadow [PAYLOAD_LEN];
  logic             shadow_we;
  logic             load_fields;
  logic             tmo_fire;
  logic             pkt_valid_d, pkt_err_d;
  logic [1:0]       err_code_d;

  // One CRC-8 byte step, MSB first
  function automatic logic [7:0] crc8_next(input logic [7:0] c, input logic [7:0] d);
    logic [7:0] r;
    r = c ^ d;
    for (int i = 0; i < 8; i++) begin
      r = r[7] ? ((r << 1) ^ CRC_POLY) : (r << 1);
    end
    return r;
  endfunction

  always_comb begin
    state_d     = state;
    byte_cnt_d  = byte_cnt;
    crc_d       = crc;
    crc_ok_d    = crc_ok;
    shadow_we   = 1'b0;
    load_fields = 1'b0;
    pkt_valid_d = 1'b0;
    pkt_err_d   = 1'b0;
    err_code_d  = err_code;
    // Any byte arriving this cycle (footer included) takes precedence over the timeout
    tmo_fire    = (state != S_IDLE) && !rx_valid && (tmo_cnt == TMO_W'(TIMEOUT_CYC - 1));

    case (state)
      S_IDLE: begin
        if (rx_valid && rx_data == HEADER) begin
          state_d    = S_PAYLOAD;
          byte_cnt_d = '0;
          crc_d      = crc8_next(8'h00, HEADER);
        end
      end
      S_PAYLOAD: begin
        if (rx_valid) begin
          shadow_we  = 1'b1;
          crc_d      = crc8_next(crc, rx_data);
          byte_cnt_d = CNT_W'(byte_cnt + 1'b1);
          if (byte_cnt == CNT_W'(PAYLOAD_LEN - 1)) state_d = S_CRC;
        end
      end
      S_CRC: begin
        if (rx_valid) begin
          crc_ok_d = (rx_data == crc);
          state_d  = S_FOOTER;
        end
      end
      S_FOOTER: begin
        if (rx_valid) begin
          state_d = S_IDLE;
          if (rx_data != FOOTER) begin
            pkt_err_d  = 1'b1;
            err_code_d = 2'b10;
          end else if (!crc_ok) begin
            pkt_err_d  = 1'b1;
            err_code_d = 2'b01;
          end else begin
            load_fields = 1'b1;
            pkt_valid_d = 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (tmo_fire) begin
      state_d    = S_IDLE;
      pkt_err_d  = 1'b1;
      err_code_d = 2'b11;
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state         <= S_IDLE;
      byte_cnt      <= '0;
      crc           <= '0;
      crc_ok        <= 1'b0;
      tmo_cnt       <= '0;
      busy          <= 1'b0;
      pkt_valid     <= 1'b0;
      pkt_err       <= 1'b0;
      err_code      <= '0;
      reg_func      <= '0;
      pwm_ch        <= '0;
      ctrl_sta      <= '0;
      duty_num      <= '0;
      pulse_dessert <= '0;
      pulse_num     <= '0;
      pattern       <= '0;
      for (int i = 0; i < PAYLOAD_LEN; i++) shadow[i] <= '0;
    end else begin
      state     <= state_d;
      byte_cnt  <= byte_cnt_d;
      crc       <= crc_d;
      crc_ok    <= crc_ok_d;
      busy      <= (state_d != S_IDLE);
      pkt_valid <= pkt_valid_d;
      pkt_err   <= pkt_err_d;
      err_code  <= err_code_d;
      tmo_cnt   <= (state == S_IDLE || rx_valid) ? '0 : TMO_W'(tmo_cnt + 1'b1);
      if (shadow_we) shadow[byte_cnt] <= rx_data;
      // Fields only ever change on a fully validated frame
      if (load_fields) begin
        reg_func      <= shadow[0];
        pwm_ch        <= shadow[1];
        ctrl_sta      <= shadow[2];
        duty_num      <= shadow[3];
        pulse_dessert <= {shadow[4], shadow[5]};
        pulse_num     <= shadow[6];
        pattern       <= {shadow[7], shadow[8], shadow[9], shadow[10]};
      end
    end
  end

endmodule

// File: tb/tb_uart_cmd_frame_decoder.sv
// Self-checking bench for uart_cmd_frame_decoder: table of frames plus hand-written
// timeout, footer/timeout race, garbage and mid-frame reset sequences.
module tb_uart_cmd_frame_decoder;

  localparam int unsigned TMO = 200;

  logic        sys_clk = 1'b0;
  logic        sys_rst_n;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        pkt_valid, pkt_err, busy;
  logic [1:0]  err_code;
  logic [7:0]  reg_func, pwm_ch, ctrl_sta, duty_num, pulse_num;
  logic [15:0] pulse_dessert;
  logic [31:0] pattern;

  uart_cmd_frame_decoder #(.TIMEOUT_CYC(TMO)) dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .rx_data(rx_data), .rx_valid(rx_valid),
    .pkt_valid(pkt_valid), .pkt_err(pkt_err), .err_code(err_code), .reg_func(reg_func),
    .pwm_ch(pwm_ch), .ctrl_sta(ctrl_sta), .duty_num(duty_num), .pulse_dessert(pulse_dessert),
    .pulse_num(pulse_num), .pattern(pattern), .busy(busy)
  );

  always #5 sys_clk = ~sys_clk;

  typedef struct packed {
    logic [7:0]  func, ch, ctrl, duty;
    logic [15:0] dess;
    logic [7:0]  pnum;
    logic [31:0] pat;
  } fields_t;

  typedef struct {
    logic       is_err;
    logic [1:0] code;
    fields_t    f;
    longint     due;
  } exp_t;

  typedef struct {
    fields_t    f;
    logic [7:0] crc_flip;
    logic [7:0] footer;
    int         gap;
    logic       exp_err;
    logic [1:0] exp_code;
  } vec_t;

  typedef logic [13:0][7:0] frame_t;

  exp_t    sb_q[$];
  fields_t mdl_f;
  logic [1:0] mdl_code;
  int      n_checks = 0;
  int      n_fail   = 0;
  longint  cyc      = 0;

  // Bit-serial CRC-8, poly 0x07, MSB first
  function automatic logic [7:0] crc8(input logic [7:0] c, input logic [7:0] d);
    logic [7:0] r;
    logic fb;
    r = c;
    for (int i = 7; i >= 0; i--) begin
      fb = r[7] ^ d[i];
      r  = {r[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
    end
    return r;
  endfunction

  function automatic frame_t build(input fields_t f, input logic [7:0] flip, input logic [7:0] ftr);
    frame_t fr;
    logic [7:0] c;
    fr[0]  = 8'h55;         fr[1]  = f.func;        fr[2] = f.ch;   fr[3] = f.ctrl;
    fr[4]  = f.duty;        fr[5]  = f.dess[15:8];  fr[6] = f.dess[7:0];
    fr[7]  = f.pnum;        fr[8]  = f.pat[31:24];  fr[9] = f.pat[23:16];
    fr[10] = f.pat[15:8];   fr[11] = f.pat[7:0];
    c = 8'h00;
    for (int i = 0; i < 12; i++) c = crc8(c, fr[i]);
    fr[12] = c ^ flip;
    fr[13] = ftr;
    return fr;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Scoreboard monitor, run once per cycle just after the active edge
  task automatic monitor();
    exp_t e;
    if (pkt_valid && pkt_err) chk("strobes_exclusive", 64'(pkt_valid & pkt_err), 64'd0);
    if (pkt_valid || pkt_err) begin
      if (sb_q.size() == 0) begin
        chk("unexpected_strobe", {62'd0, pkt_err, pkt_valid}, 64'd0);
      end else begin
        e = sb_q.pop_front();
        chk("strobe_kind",   64'(pkt_err), 64'(e.is_err));
        chk("strobe_cycle",  64'(cyc), 64'(e.due));
        chk("err_code",      64'(err_code), 64'(e.code));
        chk("reg_func",      64'(reg_func), 64'(e.f.func));
        chk("pwm_ch",        64'(pwm_ch), 64'(e.f.ch));
        chk("ctrl_sta",      64'(ctrl_sta), 64'(e.f.ctrl));
        chk("duty_num",      64'(duty_num), 64'(e.f.duty));
        chk("pulse_dessert", 64'(pulse_dessert), 64'(e.f.dess));
        chk("pulse_num",     64'(pulse_num), 64'(e.f.pnum));
        chk("pattern",       64'(pattern), 64'(e.f.pat));
      end
    end
  endtask

  task automatic tick();
    @(posedge sys_clk);
    #1;
    cyc++;
    monitor();
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
  endtask

  task automatic expect_result(input logic is_err, input logic [1:0] code, input fields_t f,
                               input longint due);
    exp_t e;
    if (is_err) mdl_code = code;
    else        mdl_f    = f;
    e.is_err = is_err;
    e.code   = mdl_code;
    e.f      = mdl_f;
    e.due    = due;
    sb_q.push_back(e);
  endtask

  task automatic send_frame(input frame_t fr, input int gap, input logic is_err,
                            input logic [1:0] code, input fields_t f);
    for (int i = 0; i < 13; i++) begin
      send_byte(fr[i]);
      repeat (gap) tick();
    end
    expect_result(is_err, code, f, cyc + 1);
    send_byte(fr[13]);
  endtask

  task automatic check_cleared(input string tag);
    chk({tag, "_busy"},     64'(busy), 64'd0);
    chk({tag, "_err_code"}, 64'(err_code), 64'd0);
    chk({tag, "_reg_func"}, 64'(reg_func), 64'd0);
    chk({tag, "_pattern"},  64'(pattern), 64'd0);
    chk({tag, "_dessert"},  64'(pulse_dessert), 64'd0);
    chk({tag, "_strobes"},  64'({pkt_valid, pkt_err}), 64'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t    vecs [7];
    frame_t  fr;
    fields_t fa, fb, fg;

    vecs[0] = '{'{8'h02, 8'h01, 8'h01, 8'h00, 16'h0000, 8'h00, 32'h0000_0000}, 8'h00, 8'hAA, 0, 1'b0, 2'b00};
    vecs[1] = '{'{8'h02, 8'h01, 8'h01, 8'h00, 16'h0000, 8'h00, 32'h0000_0000}, 8'h01, 8'hAA, 1, 1'b1, 2'b01};
    vecs[2] = '{'{8'h01, 8'h03, 8'h80, 8'h7F, 16'h1234, 8'h05, 32'hDEAD_BEEF}, 8'h00, 8'hAB, 2, 1'b1, 2'b10};
    vecs[3] = '{'{8'h01, 8'h03, 8'h80, 8'h7F, 16'h1234, 8'h05, 32'hDEAD_BEEF}, 8'h00, 8'hAA, 0, 1'b0, 2'b00};
    vecs[4] = '{'{8'h02, 8'hFF, 8'h00, 8'hFF, 16'hFFFF, 8'hFF, 32'hFFFF_FFFF}, 8'h00, 8'hAA, 1, 1'b0, 2'b00};
    vecs[5] = '{'{8'h01, 8'h02, 8'h03, 8'h04, 16'h0506, 8'h07, 32'h0809_0A0B}, 8'h80, 8'h00, 0, 1'b1, 2'b10};
    vecs[6] = '{'{8'h01, 8'h55, 8'hAA, 8'h55, 16'h55AA, 8'h55, 32'h55AA_55AA}, 8'h00, 8'hAA, 0, 1'b0, 2'b00};

    sys_rst_n = 1'b0;
    rx_valid  = 1'b0;
    rx_data   = 8'h00;
    mdl_f     = '0;
    mdl_code  = 2'b00;
    repeat (2) tick();
    check_cleared("reset");
    sys_rst_n = 1'b1;
    tick();

    // Table frames, back-to-back (header on the cycle after the footer)
    for (int v = 0; v < 7; v++) begin
      fr = build(vecs[v].f, vecs[v].crc_flip, vecs[v].footer);
      send_frame(fr, vecs[v].gap, vecs[v].exp_err, vecs[v].exp_code, vecs[v].f);
    end
    repeat (3) tick();
    chk("idle_after_table", 64'(busy), 64'd0);

    // Inter-byte timeout after 5 bytes, then recovery
    fa = '{8'h02, 8'h07, 8'h01, 8'h40, 16'h00C8, 8'h10, 32'h0102_0304};
    fr = build(fa, 8'h00, 8'hAA);
    for (int i = 0; i < 5; i++) send_byte(fr[i]);
    expect_result(1'b1, 2'b11, '0, cyc + TMO);
    for (int k = 0; k < int'(TMO) + 20 && sb_q.size() != 0; k++) tick();
    if (sb_q.size() != 0) begin
      chk("timeout_wait", 64'(sb_q.size()), 64'd0);
      sb_q.delete();
    end
    chk("timeout_busy", 64'(busy), 64'd0);
    send_frame(fr, 0, 1'b0, 2'b00, fa);
    repeat (2) tick();

    // Footer arriving in the very cycle the timeout would fire
    fb = '{8'h01, 8'h09, 8'h02, 8'h33, 16'hABCD, 8'h20, 32'hCAFE_F00D};
    fr = build(fb, 8'h00, 8'hAA);
    for (int i = 0; i < 13; i++) send_byte(fr[i]);
    repeat (TMO - 1) tick();
    expect_result(1'b0, 2'b00, fb, cyc + 1);
    send_byte(fr[13]);
    tick();
    chk("race_busy", 64'(busy), 64'd0);

    // Garbage bytes ignored, then a frame with 0x55 in pat2
    send_byte(8'h00);
    send_byte(8'h13);
    send_byte(8'hAA);
    chk("garbage_busy", 64'(busy), 64'd0);
    fg = '{8'h02, 8'h04, 8'h00, 8'h10, 16'h0001, 8'h03, 32'h1155_2233};
    send_frame(build(fg, 8'h00, 8'hAA), 1, 1'b0, 2'b00, fg);
    tick();
    chk("pat2_header_data", 64'(pattern[23:16]), 64'h55);

    // Reset after byte 8 discards the partial frame
    fr = build(fa, 8'h00, 8'hAA);
    for (int i = 0; i < 8; i++) send_byte(fr[i]);
    sys_rst_n = 1'b0;
    mdl_f     = '0;
    mdl_code  = 2'b00;
    repeat (3) tick();
    check_cleared("mid_reset");
    sys_rst_n = 1'b1;
    tick();
    send_frame(fr, 0, 1'b0, 2'b00, fa);

    repeat (5) tick();
    chk("scoreboard_drained", 64'(sb_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
